wb_soc_regbank: RTL and testbench
=================================

# wb_soc_regbank

Parametrised Wishbone classic slave register bank with a vectored, maskable interrupt controller. It exposes N_REGS 32-bit configuration registers with byte-lane writes, plus pending/mask interrupt registers for N_IRQ sources. ACK is registered, giving one wait state per access, and out-of-range accesses terminate with ERR. It sits on the SoC Wishbone bus as the control/status slave for a processing module and drives a single `irq` line to the interrupt controller.

## Interface
- N_REGS, 4: number of 32-bit general registers (1..64)
- N_IRQ, 4: number of interrupt sources (1..32)
- p_clk  in  1  clock; all logic on rising edge
- p_reset  in  1  synchronous, active-high reset
- raise_irq  in  N_IRQ  per-source interrupt request, level-sampled each cycle
- irq  out  1  |(pending & mask), registered
- module_register  out  32*N_REGS  register i on bits [32i+31:32i]
- initialized  out  N_REGS  sticky: register i written at least once since reset
- written  out  N_REGS  one-cycle pulse: register i written this cycle
- p_wb_DAT_I  in  32  write data
- p_wb_DAT_O  out  32  read data, valid while ACK is high
- p_wb_ADR_I  in  32  byte address; word index = ADR_I[31:2]
- p_wb_SEL_I  in  4  byte enables, SEL[k] -> bits [8k+7:8k]
- p_wb_CYC_I, p_wb_STB_I, p_wb_WE_I, p_wb_LOCK_I  in  1  Wishbone controls; LOCK ignored
- p_wb_ACK_O, p_wb_ERR_O, p_wb_RTY_O  out  1  terminations; RTY tied 0

## Operation
- Word map: 0..N_REGS-1 = general regs (RW); N_REGS = IRQ_PENDING (read; write-1-to-clear, bits [N_IRQ-1:0]); N_REGS+1 = IRQ_MASK (RW, bits [N_IRQ-1:0]); every other index is invalid.
- Unused upper bits of PENDING/MASK read as 0 and ignore writes.
- A request is CYC & STB & !ack_q & !err_q. On the edge that accepts a valid request, the block:
  - sets ack_q,
  - commits a write (per-byte SEL merge), or latches read data into the DAT_O register.
- Invalid index: sets err_q instead; no state change; DAT_O = 0.
- Write with SEL = 0: ACKed, no data change. initialized/written still update (an access occurred).
- Pending: pending[i] <= (pending[i] & ~w1c[i]) | raise_irq[i]. Set wins over a simultaneous clear.
- Pending is set regardless of mask; the mask gates only `irq`.
- irq <= |(pending_next & mask_next), i.e. it reflects the register state after the current edge.
- A write to reg i sets initialized[i] and pulses written[i] high for the cycle after the committing edge.
- Reset (p_reset high at an edge) sets to 0: all regs, mask, pending, initialized, written, ack_q, err_q, DAT_O, irq. Reset overrides any in-flight access; that access is neither committed nor ACKed.

## Timing
- Latency: request sampled at edge N -> ACK/ERR high during cycle N+1 for exactly one cycle; next request accepted at edge N+1 at the earliest. Maximum throughput is one access per 2 cycles.
- p_wb_ACK_O = ack_q & CYC & STB, and p_wb_ERR_O = err_q & CYC & STB, so a master abandoning the cycle never sees a stray termination. ACK and ERR are never high together.
- Write data is visible on module_register in the same cycle ACK is high. A read issued in that cycle returns the new value.
- raise_irq high at edge N -> pending visible on read from N+1; irq high in cycle N+1 if the mask bit is set.
- Clearing a mask bit drops irq on the next edge even if pending remains set.
- Abort mid-access (CYC falls during the ACK cycle): the write has already committed; ack_q self-clears at the next edge.

## Test plan
- Reset for 2 cycles -> all outputs 0; read word 0 returns 0x00000000 with ACK one cycle after STB.
- N_REGS=4: write 0xDEADBEEF to addr 0x8 with SEL=0xF, then write 0x000000AA with SEL=0x1 -> reg2 = 0xDEADBEAA; written[2] pulses twice; initialized = 4'b0100.
- Access addr 0x18 (index 6, invalid) -> ERR one cycle, ACK 0, no state change; index 5 (MASK) access -> ACK.
- MASK=0x1, raise_irq=4'b0011 for 1 cycle -> PENDING reads 0x3, irq=1; W1C 0x1 -> PENDING 0x2, irq=0.
- W1C of bit 0 in the same cycle raise_irq[0]=1 -> PENDING bit 0 stays 1, irq stays 1.
- Assert p_reset during a write's accept cycle -> no ACK, target register stays 0; back-to-back STB held high yields ACK every other cycle.

Source files
------------

// File: rtl/wb_soc_regbank.sv
// Wishbone classic control/status slave: N_REGS config words, IRQ pending (W1C) and mask, one irq line.
// Latency: request sampled at edge N, ACK or ERR held for exactly cycle N+1 (one wait state).
// Backpressure: a new request is only taken once ack_q/err_q have cleared, so at most one access per 2 cycles.
module wb_soc_regbank #(
    parameter int N_REGS = 4,
    parameter int N_IRQ  = 4
) (
    input  logic                  p_clk,
    input  logic                  p_reset,
    input  logic [N_IRQ-1:0]      raise_irq,
    output logic                  irq,
    output logic [32*N_REGS-1:0]  module_register,
    output logic [N_REGS-1:0]     initialized,
    output logic [N_REGS-1:0]     written,
    input  logic [31:0]           p_wb_DAT_I,
    output logic [31:0]           p_wb_DAT_O,
    input  logic [31:0]           p_wb_ADR_I,
    input  logic [3:0]            p_wb_SEL_I,
    input  logic                  p_wb_CYC_I,
    input  logic                  p_wb_STB_I,
    input  logic                  p_wb_WE_I,
    input  logic                  p_wb_LOCK_I,
    output logic                  p_wb_ACK_O,
    output logic                  p_wb_ERR_O,
    output logic                  p_wb_RTY_O
);
    localparam int PEND_IDX = N_REGS;
    localparam int MASK_IDX = N_REGS + 1;

    logic [31:0]       regs [N_REGS];
    logic [N_IRQ-1:0]  pending;
    logic [N_IRQ-1:0]  mask;
    logic              ack_q;
    logic              err_q;
    logic [31:0]       dat_q;

    logic [29:0]       idx;
    logic              req;
    logic              valid;
    logic              acc;
    logic              wr;
    logic              bad;
    logic [31:0]       bmask;
    logic [31:0]       wbits;
    logic [N_REGS-1:0] reg_we;
    logic [N_IRQ-1:0]  w1c;
    logic [N_IRQ-1:0]  pend_nxt;
    logic [N_IRQ-1:0]  mask_nxt;
    logic [31:0]       rdata;
    logic              unused_ok;

    assign idx   = p_wb_ADR_I[31:2];
    assign req   = p_wb_CYC_I & p_wb_STB_I & ~ack_q & ~err_q;
    assign valid = idx < 30'(N_REGS + 2);
    assign acc   = req & valid;
    assign wr    = acc & p_wb_WE_I;
    assign bad   = req & ~valid;
    assign bmask = {{8{p_wb_SEL_I[3]}}, {8{p_wb_SEL_I[2]}}, {8{p_wb_SEL_I[1]}}, {8{p_wb_SEL_I[0]}}};
    assign wbits = p_wb_DAT_I & bmask;

    always_comb begin
        reg_we = '0;
        rdata  = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (idx == 30'(i)) begin
                reg_we[i] = wr;
                rdata     = regs[i];
            end
        end
        if (idx == 30'(PEND_IDX)) rdata[N_IRQ-1:0] = pending;
        if (idx == 30'(MASK_IDX)) rdata[N_IRQ-1:0] = mask;

        w1c      = (wr && idx == 30'(PEND_IDX)) ? wbits[N_IRQ-1:0] : '0;
        // A fresh request on the same edge beats the software clear
        pend_nxt = (pending & ~w1c) | raise_irq;
        mask_nxt = mask;
        if (wr && idx == 30'(MASK_IDX))
            mask_nxt = (mask & ~bmask[N_IRQ-1:0]) | wbits[N_IRQ-1:0];
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
            pending     <= '0;
            mask        <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            irq         <= 1'b0;
            initialized <= '0;
            written     <= '0;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (reg_we[i]) regs[i] <= (regs[i] & ~bmask) | wbits;
            end
            ack_q       <= acc;
            err_q       <= bad;
            dat_q       <= (acc && !p_wb_WE_I) ? rdata : '0;
            pending     <= pend_nxt;
            mask        <= mask_nxt;
            irq         <= |(pend_nxt & mask_nxt);
            initialized <= initialized | reg_we;
            written     <= reg_we;
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_out
        assign module_register[32*g +: 32] = regs[g];
    end

    // Gating with CYC&STB hides a termination from a master that already walked away
    assign p_wb_ACK_O = ack_q & p_wb_CYC_I & p_wb_STB_I;
    assign p_wb_ERR_O = err_q & p_wb_CYC_I & p_wb_STB_I;
    assign p_wb_RTY_O = 1'b0;
    assign p_wb_DAT_O = dat_q;

    assign unused_ok = ^{p_wb_LOCK_I, p_wb_ADR_I[1:0], wbits, bmask};
endmodule

// File: tb/tb_wb_soc_regbank.sv
// Bench for wb_soc_regbank: bus transactions push expectations from a reference model into a
// queue, and each ACK/ERR pops and compares; scenario tasks add direct checks on side outputs.
module tb_wb_soc_regbank;
    localparam int N_REGS = 4;
    localparam int N_IRQ  = 4;

    logic                 p_clk = 1'b0;
    logic                 p_reset;
    logic [N_IRQ-1:0]     raise_irq;
    logic                 irq;
    logic [32*N_REGS-1:0] module_register;
    logic [N_REGS-1:0]    initialized;
    logic [N_REGS-1:0]    written;
    logic [31:0]          dat_i, dat_o, adr;
    logic [3:0]           sel;
    logic                 cyc, stb, we, lock;
    logic                 ack, err, rty;

    wb_soc_regbank #(.N_REGS(N_REGS), .N_IRQ(N_IRQ)) dut (
        .p_clk(p_clk), .p_reset(p_reset), .raise_irq(raise_irq), .irq(irq),
        .module_register(module_register), .initialized(initialized), .written(written),
        .p_wb_DAT_I(dat_i), .p_wb_DAT_O(dat_o), .p_wb_ADR_I(adr), .p_wb_SEL_I(sel),
        .p_wb_CYC_I(cyc), .p_wb_STB_I(stb), .p_wb_WE_I(we), .p_wb_LOCK_I(lock),
        .p_wb_ACK_O(ack), .p_wb_ERR_O(err), .p_wb_RTY_O(rty)
    );

    always #5 p_clk = ~p_clk;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    exp_t              exp_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                wr2_cnt = 0;
    logic [31:0]       m_regs [N_REGS];
    logic [N_IRQ-1:0]  m_pend;
    logic [N_IRQ-1:0]  m_mask;
    logic [N_REGS-1:0] m_init;

    always @(negedge p_clk) if (written[2] === 1'b1) wr2_cnt++;

    function automatic logic [31:0] bm(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [32*N_REGS-1:0] m_pack();
        logic [32*N_REGS-1:0] r;
        for (int i = 0; i < N_REGS; i++) r[32*i +: 32] = m_regs[i];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        logic [31:0] r;
        r = '0;
        if (idx < N_REGS) r = m_regs[idx];
        else if (idx == N_REGS) r[N_IRQ-1:0] = m_pend;
        else if (idx == N_REGS + 1) r[N_IRQ-1:0] = m_mask;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_REGS; i++) m_regs[i] = '0;
        m_pend = '0;
        m_mask = '0;
        m_init = '0;
        exp_q.delete();
    endtask

    // Predicts the response of one access and advances the model as the DUT should.
    task automatic push_and_model(input logic [31:0] a, input logic w, input logic [31:0] d,
                                  input logic [3:0] s);
        exp_t        e;
        int          idx;
        logic [31:0] m, v;
        idx   = int'(a[31:2]);
        m     = bm(s);
        v     = d & m;
        e.err = (idx >= N_REGS + 2);
        e.chk = !w || e.err;
        e.dat = (e.err || w) ? 32'h0 : m_read(idx);
        if (!e.err && w) begin
            if (idx < N_REGS) begin
                m_regs[idx] = (m_regs[idx] & ~m) | v;
                m_init[idx] = 1'b1;
            end else if (idx == N_REGS) begin
                m_pend = (m_pend & ~v[N_IRQ-1:0]) | raise_irq;
            end else begin
                m_mask = (m_mask & ~m[N_IRQ-1:0]) | v[N_IRQ-1:0];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
        exp_t e;
        int   lat;
        logic sa, se;
        @(negedge p_clk);
        push_and_model(a, w, d, s);
        adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
        lat = 0;
        do begin
            @(posedge p_clk); #1;
            lat++;
        end while (!ack && !err && lat < 8);
        sa = ack; se = err; rd = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if ({sa, se} !== {!e.err, e.err}) begin
            n_bad++;
            $display("FAIL term adr=%h: ack/err=%b%b required %b%b", a, sa, se, !e.err, e.err);
        end
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL latency adr=%h: %0d cycles required 1", a, lat);
        end
        if (e.chk) begin
            n_cmp++;
            if (rd !== e.dat) begin
                n_bad++;
                $display("FAIL rdata adr=%h: got %h required %h", a, rd, e.dat);
            end
        end
        @(posedge p_clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        p_reset = 1'b1;
        repeat (2) @(posedge p_clk);
        #1;
        model_reset();
        n_cmp++;
        if ({irq, module_register, initialized, written, ack, err, rty, dat_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: irq=%b regs=%h init=%b wr=%b ack=%b err=%b rty=%b dat=%h required all 0",
                     irq, module_register, initialized, written, ack, err, rty, dat_o);
        end
        @(negedge p_clk);
        p_reset = 1'b0;
        xfer(32'h0, 1'b0, 32'h0, 4'hF, rd);
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        int          c0;
        c0 = wr2_cnt;
        xfer(32'h8, 1'b1, 32'hDEADBEEF, 4'hF, rd);
        xfer(32'h8, 1'b1, 32'h000000AA, 4'h1, rd);
        n_cmp++;
        if (module_register !== m_pack()) begin
            n_bad++;
            $display("FAIL reg_merge: regs=%h required %h", module_register, m_pack());
        end
        n_cmp++;
        if (module_register[95:64] !== 32'hDEADBEAA) begin
            n_bad++;
            $display("FAIL reg2: %h required deadbeaa", module_register[95:64]);
        end
        n_cmp++;
        if (wr2_cnt - c0 !== 2) begin
            n_bad++;
            $display("FAIL written2_pulses: %0d required 2", wr2_cnt - c0);
        end
        n_cmp++;
        if (initialized !== 4'b0100) begin
            n_bad++;
            $display("FAIL initialized: %b required 0100", initialized);
        end
        xfer(32'h8, 1'b0, 32'h0, 4'hF, rd);
        xfer(32'hC, 1'b1, 32'hFFFFFFFF, 4'h0, rd);
        n_cmp++;
        if ({initialized, module_register} !== {m_init, m_pack()}) begin
            n_bad++;
            $display("FAIL sel0_write: init=%b regs=%h required init=%b regs=%h",
                     initialized, module_register, m_init, m_pack());
        end
    endtask

    task automatic test_err();
        logic [31:0] rd;
        xfer(32'h18, 1'b0, 32'h0, 4'hF, rd);
        xfer(32'h18, 1'b1, 32'hFFFFFFFF, 4'hF, rd);
        n_cmp++;
        if ({initialized, module_register} !== {m_init, m_pack()}) begin
            n_bad++;
            $display("FAIL err_no_change: init=%b regs=%h required init=%b regs=%h",
                     initialized, module_register, m_init, m_pack());
        end
        xfer(32'h14, 1'b1, 32'hFFFFFFFF, 4'hF, rd);
        xfer(32'h14, 1'b0, 32'h0, 4'hF, rd);
        xfer(32'h10, 1'b0, 32'h0, 4'hF, rd);
        xfer(32'h14, 1'b1, 32'h0, 4'hF, rd);
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        xfer(32'h14, 1'b1, 32'h1, 4'hF, rd);
        @(negedge p_clk);
        raise_irq = 4'b0011;
        @(negedge p_clk);
        raise_irq = 4'b0000;
        m_pend = m_pend | 4'b0011;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_raise: %b required 1", irq);
        end
        xfer(32'h10, 1'b0, 32'h0, 4'hF, rd);
        xfer(32'h10, 1'b1, 32'h1, 4'hF, rd);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_after_w1c: %b required 0", irq);
        end
        xfer(32'h10, 1'b0, 32'h0, 4'hF, rd);
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd;
        @(negedge p_clk);
        raise_irq = 4'b0001;
        xfer(32'h10, 1'b1, 32'h1, 4'hF, rd);
        @(negedge p_clk);
        raise_irq = 4'b0000;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_race: %b required 1", irq);
        end
        xfer(32'h10, 1'b0, 32'h0, 4'hF, rd);
        xfer(32'h14, 1'b1, 32'h0, 4'hF, rd);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_mask_clear: %b required 0", irq);
        end
        xfer(32'h10, 1'b1, 32'hF, 4'hF, rd);
    endtask

    task automatic test_reset_abort();
        @(negedge p_clk);
        adr = 32'h4; dat_i = 32'h12345678; sel = 4'hF; we = 1'b1;
        cyc = 1'b1; stb = 1'b1; p_reset = 1'b1;
        @(posedge p_clk); #1;
        model_reset();
        n_cmp++;
        if ({ack, err, module_register} !== '0) begin
            n_bad++;
            $display("FAIL reset_abort: ack=%b err=%b regs=%h required all 0", ack, err, module_register);
        end
        @(negedge p_clk);
        p_reset = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge p_clk); #1;
        n_cmp++;
        if ({ack, initialized} !== '0) begin
            n_bad++;
            $display("FAIL reset_abort_after: ack=%b init=%b required 0", ack, initialized);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        exp_t        e;
        xfer(32'h0, 1'b1, 32'hA5A50001, 4'hF, rd);
        @(negedge p_clk);
        for (int k = 0; k < 4; k++) push_and_model(32'h0, 1'b0, 32'h0, 4'hF);
        adr = 32'h0; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge p_clk); #1;
            n_cmp++;
            if (ack !== logic'(k % 2)) begin
                n_bad++;
                $display("FAIL b2b_ack cycle %0d: %b required %b", k, ack, k % 2);
            end
            if (ack === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (dat_o !== e.dat) begin
                    n_bad++;
                    $display("FAIL b2b_rdata cycle %0d: %h required %h", k, dat_o, e.dat);
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL b2b_outstanding: %0d left required 0", exp_q.size());
        end
    endtask

    initial begin
        p_reset = 1'b1; raise_irq = '0; dat_i = '0; adr = '0; sel = '0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; lock = 1'b0;
        model_reset();
        test_reset();
        test_regs();
        test_err();
        test_irq();
        test_w1c_race();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(posedge p_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
